alu_issue_ctrl: RTL and testbench

Multi-cycle issue controller that sits in front of the ALU, on the opposite end of its `alu_in_1` / `alu_in_2` / `alu_op` / `alu_result` / `alu_bcond` interface. It accepts one instruction with operands over a valid/ready request port and decodes it to an ALU operation. It drives the ALU from registers, captures the result and branch condition flags, and returns them over a valid/ready response port. It is the execute-stage building block for the multi-cycle datapath.

---
 rtl/alu_issue_pkg.sv | 50 +++++
 rtl/alu_issue_if.sv | 25 ++
 rtl/alu_issue_decode.sv | 75 +++++++
 rtl/alu_issue_ctrl.sv | 117 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_pkg.sv
// rtl/alu_issue_pkg.sv - opcodes, alu_op codes, FSM states and decoded-op struct for the ALU issue controller
package alu_issue_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_RESP} state_t;

  typedef enum logic [1:0] {SEL1_RS1, SEL1_PC, SEL1_ZERO} sel1_t;

  typedef enum logic [2:0] {
    SEL2_RS2, SEL2_RS2_SH, SEL2_IMM, SEL2_IMM_SH, SEL2_FOUR, SEL2_ZERO
  } sel2_t;

  typedef struct packed {
    logic [3:0] op;
    sel1_t      sel1;
    sel2_t      sel2;
    logic       is_branch;
    logic       is_jump;
    logic       illegal;
  } dec_t;

  // bcond: [0] zero, [1] negative, [2] positive, taken from rs1-rs2
  function automatic logic branch_taken(input logic [2:0] funct3, input logic [2:0] bcond);
    case (funct3)
      3'b000:  return bcond[0];
      3'b001:  return ~bcond[0];
      3'b100:  return bcond[1];
      3'b101:  return bcond[0] | bcond[2];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// rtl/alu_issue_if.sv - request/response handshake bundle between requester and ALU issue controller
interface alu_issue_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_inst;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [31:0] req_imm;
  logic [31:0] req_pc;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_taken;
  logic        rsp_illegal;

  modport master (
    output req_valid, req_inst, req_rs1, req_rs2, req_imm, req_pc, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_taken, rsp_illegal
  );

  modport slave (
    input  req_valid, req_inst, req_rs1, req_rs2, req_imm, req_pc, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_taken, rsp_illegal
  );
endinterface

// File: rtl/alu_issue_decode.sv
// rtl/alu_issue_decode.sv - combinational RV32 instruction to ALU op decode
// Branch decode present only when ALU_ISSUE_BRANCH_EN is defined.
module alu_issue_decode
  import alu_issue_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output dec_t       dec
);

  always_comb begin
    dec = '{op: ALU_ADD, sel1: SEL1_RS1, sel2: SEL2_RS2,
            is_branch: 1'b0, is_jump: 1'b0, illegal: 1'b0};
    case (opcode)
      OPC_OP: begin
        // funct7 may only be nonzero for SUB, so funct7[5] is inst[30] here
        if (funct7 == 7'b0000000 || (funct7 == 7'b0100000 && funct3 == 3'b000)) begin
          case ({funct7[5], funct3})
            4'b0000: dec.op = ALU_ADD;
            4'b1000: dec.op = ALU_SUB;
            4'b0111: dec.op = ALU_AND;
            4'b0110: dec.op = ALU_OR;
            4'b0100: dec.op = ALU_XOR;
            4'b0001: begin dec.op = ALU_SLL; dec.sel2 = SEL2_RS2_SH; end
            4'b0101: begin dec.op = ALU_SRL; dec.sel2 = SEL2_RS2_SH; end
            default: dec.illegal = 1'b1;
          endcase
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec.sel2 = SEL2_IMM;
        case (funct3)
          3'b000: dec.op = ALU_ADD;
          3'b100: dec.op = ALU_XOR;
          3'b110: dec.op = ALU_OR;
          3'b111: dec.op = ALU_AND;
          3'b001: begin dec.op = ALU_SLL; dec.sel2 = SEL2_IMM_SH; end
          3'b101: begin
            dec.op      = ALU_SRL;
            dec.sel2    = SEL2_IMM_SH;
            dec.illegal = funct7[5];
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_LOAD, OPC_STORE: dec.sel2 = SEL2_IMM;
`ifdef ALU_ISSUE_BRANCH_EN
      OPC_BRANCH: begin
        dec.op        = ALU_SUB;
        dec.is_branch = 1'b1;
        dec.illegal   = ~(funct3 == 3'b000 || funct3 == 3'b001 ||
                          funct3 == 3'b100 || funct3 == 3'b101);
      end
`endif
      OPC_JAL, OPC_JALR: begin
        dec.sel1    = SEL1_PC;
        dec.sel2    = SEL2_FOUR;
        dec.is_jump = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase

    if (dec.illegal) begin
      dec.op        = ALU_ADD;
      dec.sel1      = SEL1_ZERO;
      dec.sel2      = SEL2_ZERO;
      dec.is_branch = 1'b0;
      dec.is_jump   = 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - three-state issue controller driving the ALU from registers
// Optional branch resolution under ALU_ISSUE_BRANCH_EN.
module alu_issue_ctrl
  import alu_issue_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  alu_issue_if.slave  bus,
  output logic [31:0] alu_in_1,
  output logic [31:0] alu_in_2,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic [2:0]  alu_bcond
);

  state_t      state, state_nxt;
  dec_t        dec;
  logic        accept;
  logic [31:0] op1, op2;
  logic        pend_jump, pend_illegal;
  logic        br_taken;
  logic        unused_inst;

  alu_issue_decode u_decode (
    .opcode (bus.req_inst[6:0]),
    .funct3 (bus.req_inst[14:12]),
    .funct7 (bus.req_inst[31:25]),
    .dec    (dec)
  );

  assign unused_inst   = ^{bus.req_inst[24:15], bus.req_inst[11:7]};
  assign bus.req_ready = (state == ST_IDLE) & ~reset;
  assign bus.rsp_valid = (state == ST_RESP);
  assign accept        = bus.req_valid & bus.req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_DRIVE;
      ST_DRIVE: state_nxt = ST_RESP;
      ST_RESP:  if (bus.rsp_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    op1 = 32'h0;
    op2 = 32'h0;
    case (dec.sel1)
      SEL1_RS1: op1 = bus.req_rs1;
      SEL1_PC:  op1 = bus.req_pc;
      default:  op1 = 32'h0;
    endcase
    case (dec.sel2)
      SEL2_RS2:    op2 = bus.req_rs2;
      SEL2_RS2_SH: op2 = {27'b0, bus.req_rs2[4:0]};
      SEL2_IMM:    op2 = bus.req_imm;
      SEL2_IMM_SH: op2 = {27'b0, bus.req_imm[4:0]};
      SEL2_FOUR:   op2 = 32'd4;
      default:     op2 = 32'h0;
    endcase
  end

`ifdef ALU_ISSUE_BRANCH_EN
  logic       pend_branch;
  logic [2:0] pend_f3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_branch <= 1'b0;
      pend_f3     <= 3'b000;
    end else if (accept) begin
      pend_branch <= dec.is_branch;
      pend_f3     <= bus.req_inst[14:12];
    end
  end

  assign br_taken = pend_branch & branch_taken(pend_f3, alu_bcond);
`else
  logic unused_branch;
  assign unused_branch = ^{alu_bcond, dec.is_branch};
  assign br_taken      = 1'b0;
`endif

  // ALU inputs change only on accept so they stay stable through DRIVE and RESP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_in_1        <= 32'h0;
      alu_in_2        <= 32'h0;
      alu_op          <= ALU_ADD;
      pend_jump       <= 1'b0;
      pend_illegal    <= 1'b0;
      bus.rsp_result  <= 32'h0;
      bus.rsp_taken   <= 1'b0;
      bus.rsp_illegal <= 1'b0;
    end else begin
      if (accept) begin
        alu_in_1     <= op1;
        alu_in_2     <= op2;
        alu_op       <= dec.op;
        pend_jump    <= dec.is_jump;
        pend_illegal <= dec.illegal;
      end
      if (state == ST_DRIVE) begin
        bus.rsp_result  <= pend_illegal ? 32'h0 : alu_result;
        bus.rsp_taken   <= ~pend_illegal & (pend_jump | br_taken);
        bus.rsp_illegal <= pend_illegal;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - table-driven bench for alu_issue_ctrl with a behavioural ALU
// Branch vectors follow ALU_ISSUE_BRANCH_EN.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] alu_in_1, alu_in_2, alu_result;
  logic [3:0]  alu_op;
  logic [2:0]  alu_bcond;

  int n_vec  = 0;
  int n_fail = 0;

  alu_issue_if bus ();

  alu_issue_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .alu_in_1   (alu_in_1),
    .alu_in_2   (alu_in_2),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_bcond  (alu_bcond)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_result = 32'h0;
    case (alu_op)
      4'b0000: alu_result = alu_in_1 & alu_in_2;
      4'b0001: alu_result = alu_in_1 | alu_in_2;
      4'b0010: alu_result = alu_in_1 + alu_in_2;
      4'b0110: alu_result = alu_in_1 - alu_in_2;
      4'b0011: alu_result = alu_in_1 << alu_in_2[4:0];
      4'b0111: alu_result = alu_in_1 ^ alu_in_2;
      4'b1000: alu_result = alu_in_1 >> alu_in_2[4:0];
      default: alu_result = 32'h0;
    endcase
    alu_bcond = {$signed(alu_result) > 0, alu_result[31], alu_result == 32'h0};
  end

  typedef struct {
    string       name;
    logic [31:0] inst, rs1, rs2, imm, pc;
    logic [31:0] in1, in2;
    logic [3:0]  op;
    logic [31:0] res;
    logic        taken, illegal;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] opc);
    return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
  endfunction

  function automatic vec_t mk(input string nm, input logic [31:0] inst, rs1, rs2, imm, pc,
                              input logic [31:0] in1, in2, input logic [3:0] op,
                              input logic [31:0] res, input logic taken, illegal);
    vec_t v;
    v.name = nm; v.inst = inst; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.pc = pc;
    v.in1 = in1; v.in2 = in2; v.op = op; v.res = res; v.taken = taken; v.illegal = illegal;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive_req(input logic [31:0] inst, rs1, rs2, imm, pc);
    bus.req_valid = 1'b1;
    bus.req_inst  = inst;
    bus.req_rs1   = rs1;
    bus.req_rs2   = rs2;
    bus.req_imm   = imm;
    bus.req_pc    = pc;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " alu_in_1"}, alu_in_1, 32'h0);
    check({tag, " alu_in_2"}, alu_in_2, 32'h0);
    check({tag, " alu_op"}, {28'h0, alu_op}, 32'h2);
    check({tag, " rsp_valid"}, {31'h0, bus.rsp_valid}, 32'h0);
    check({tag, " rsp_result"}, bus.rsp_result, 32'h0);
    check({tag, " rsp_taken"}, {31'h0, bus.rsp_taken}, 32'h0);
    check({tag, " rsp_illegal"}, {31'h0, bus.rsp_illegal}, 32'h0);
    check({tag, " req_ready"}, {31'h0, bus.req_ready}, 32'h0);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_inst  = 32'h0;
    bus.req_rs1   = 32'h0;
    bus.req_rs2   = 32'h0;
    bus.req_imm   = 32'h0;
    bus.req_pc    = 32'h0;
    bus.rsp_ready = 1'b1;

    vecs.push_back(mk("add",   enc(7'h00,3'd0,7'h33), 5, 7, 0, 0,             5, 7, 4'h2, 12, 0, 0));
    vecs.push_back(mk("sub",   enc(7'h20,3'd0,7'h33), 3, 10, 0, 0,            3, 10, 4'h6, 32'hFFFFFFF9, 0, 0));
    vecs.push_back(mk("sll",   enc(7'h00,3'd1,7'h33), 1, 32'h21, 0, 0,        1, 1, 4'h3, 2, 0, 0));
    vecs.push_back(mk("slli",  enc(7'h00,3'd1,7'h13), 1, 32'h99, 5, 0,        1, 5, 4'h3, 32, 0, 0));
    vecs.push_back(mk("srai",  enc(7'h20,3'd5,7'h13), 32'h80, 0, 32'h405, 0,  0, 0, 4'h2, 0, 0, 1));
    vecs.push_back(mk("and",   enc(7'h00,3'd7,7'h33), 32'hF0F0, 32'hFF00, 0, 0, 32'hF0F0, 32'hFF00, 4'h0, 32'hF000, 0, 0));
    vecs.push_back(mk("or",    enc(7'h00,3'd6,7'h33), 32'hF0, 32'h0F, 0, 0,   32'hF0, 32'h0F, 4'h1, 32'hFF, 0, 0));
    vecs.push_back(mk("xor",   enc(7'h00,3'd4,7'h33), 32'hFF, 32'h0F, 0, 0,   32'hFF, 32'h0F, 4'h7, 32'hF0, 0, 0));
    vecs.push_back(mk("srl",   enc(7'h00,3'd5,7'h33), 32'h80000000, 32'h3F, 0, 0, 32'h80000000, 32'h1F, 4'h8, 1, 0, 0));
    vecs.push_back(mk("sra_r", enc(7'h20,3'd5,7'h33), 32'h80, 1, 0, 0,        0, 0, 4'h2, 0, 0, 1));
    vecs.push_back(mk("slt",   enc(7'h00,3'd2,7'h33), 4, 5, 0, 0,             0, 0, 4'h2, 0, 0, 1));
    vecs.push_back(mk("badf7", enc(7'h01,3'd0,7'h33), 4, 5, 0, 0,             0, 0, 4'h2, 0, 0, 1));
    vecs.push_back(mk("addi",  enc(7'h00,3'd0,7'h13), 10, 32'h77, 32'hFFFFFFFF, 0, 10, 32'hFFFFFFFF, 4'h2, 9, 0, 0));
    vecs.push_back(mk("srli",  enc(7'h00,3'd5,7'h13), 32'h100, 0, 32'h24, 0,  32'h100, 4, 4'h8, 32'h10, 0, 0));
    vecs.push_back(mk("lw",    enc(7'h00,3'd2,7'h03), 32'h1000, 0, 8, 0,      32'h1000, 8, 4'h2, 32'h1008, 0, 0));
    vecs.push_back(mk("sw",    enc(7'h00,3'd2,7'h23), 32'h2000, 3, 32'hFFFFFFFC, 0, 32'h2000, 32'hFFFFFFFC, 4'h2, 32'h1FFC, 0, 0));
    vecs.push_back(mk("jal",   enc(7'h00,3'd0,7'h6F), 0, 0, 32'h40, 32'h100,  32'h100, 4, 4'h2, 32'h104, 1, 0));
    vecs.push_back(mk("jalr",  enc(7'h00,3'd0,7'h67), 32'h55, 0, 0, 32'h200, 32'h200, 4, 4'h2, 32'h204, 1, 0));
    vecs.push_back(mk("op7f",  enc(7'h7F,3'd7,7'h7F), 1, 2, 3, 4,             0, 0, 4'h2, 0, 0, 1));
`ifdef ALU_ISSUE_BRANCH_EN
    vecs.push_back(mk("blt",   enc(7'h00,3'd4,7'h63), 32'hFFFFFFFF, 1, 0, 0,  32'hFFFFFFFF, 1, 4'h6, 32'hFFFFFFFE, 1, 0));
    vecs.push_back(mk("bge",   enc(7'h00,3'd5,7'h63), 32'hFFFFFFFF, 1, 0, 0,  32'hFFFFFFFF, 1, 4'h6, 32'hFFFFFFFE, 0, 0));
    vecs.push_back(mk("beq",   enc(7'h00,3'd0,7'h63), 9, 9, 0, 0,             9, 9, 4'h6, 0, 1, 0));
    vecs.push_back(mk("bne",   enc(7'h00,3'd1,7'h63), 9, 9, 0, 0,             9, 9, 4'h6, 0, 0, 0));
    vecs.push_back(mk("bf3x",  enc(7'h00,3'd2,7'h63), 9, 9, 0, 0,             0, 0, 4'h2, 0, 0, 1));
`else
    vecs.push_back(mk("blt_off", enc(7'h00,3'd4,7'h63), 32'hFFFFFFFF, 1, 0, 0, 0, 0, 4'h2, 0, 0, 1));
    vecs.push_back(mk("beq_off", enc(7'h00,3'd0,7'h63), 9, 9, 0, 0,           0, 0, 4'h2, 0, 0, 1));
`endif

    // reset state
    #2 reset = 1'b1;
    #1 check_reset_outputs("por");
    @(negedge clk);
    check("por held req_ready", {31'h0, bus.req_ready}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1 check("por release req_ready", {31'h0, bus.req_ready}, 32'h1);

    foreach (vecs[i]) begin
      @(negedge clk);
      check({vecs[i].name, " req_ready"}, {31'h0, bus.req_ready}, 32'h1);
      drive_req(vecs[i].inst, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].pc);
      @(negedge clk);
      bus.req_valid = 1'b0;
      check({vecs[i].name, " drive rsp_valid"}, {31'h0, bus.rsp_valid}, 32'h0);
      check({vecs[i].name, " alu_in_1"}, alu_in_1, vecs[i].in1);
      check({vecs[i].name, " alu_in_2"}, alu_in_2, vecs[i].in2);
      check({vecs[i].name, " alu_op"}, {28'h0, alu_op}, {28'h0, vecs[i].op});
      @(negedge clk);
      check({vecs[i].name, " rsp_valid"}, {31'h0, bus.rsp_valid}, 32'h1);
      check({vecs[i].name, " rsp_result"}, bus.rsp_result, vecs[i].res);
      check({vecs[i].name, " rsp_taken"}, {31'h0, bus.rsp_taken}, {31'h0, vecs[i].taken});
      check({vecs[i].name, " rsp_illegal"}, {31'h0, bus.rsp_illegal}, {31'h0, vecs[i].illegal});
    end

    // backpressure: response held for 5 cycles while a second request waits
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    drive_req(enc(7'h00,3'd0,7'h33), 5, 7, 0, 0);
    @(negedge clk);
    drive_req(enc(7'h00,3'd0,7'h33), 1, 1, 0, 0);
    check("bp drive alu_in_1", alu_in_1, 32'd5);
    repeat (5) begin
      @(negedge clk);
      check("bp rsp_valid", {31'h0, bus.rsp_valid}, 32'h1);
      check("bp rsp_result", bus.rsp_result, 32'd12);
      check("bp req_ready", {31'h0, bus.req_ready}, 32'h0);
      check("bp alu_in_1 held", alu_in_1, 32'd5);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp idle req_ready", {31'h0, bus.req_ready}, 32'h1);
    check("bp idle rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("bp second alu_in_1", alu_in_1, 32'd1);
    check("bp second alu_in_2", alu_in_2, 32'd1);
    @(negedge clk);
    check("bp second rsp_valid", {31'h0, bus.rsp_valid}, 32'h1);
    check("bp second rsp_result", bus.rsp_result, 32'd2);

    // reset asserted during DRIVE drops the transaction
    @(negedge clk);
    drive_req(enc(7'h00,3'd0,7'h33), 5, 7, 0, 0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rst_mid drive alu_in_1", alu_in_1, 32'd5);
    reset = 1'b1;
    #1 check_reset_outputs("rst_mid");
    @(negedge clk);
    reset = 1'b0;
    #1 check("rst_mid release req_ready", {31'h0, bus.req_ready}, 32'h1);
    repeat (3) begin
      @(negedge clk);
      check("rst_mid no rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
